// File: rtl/mnist_pkg.sv
// Shared defaults and FSM encoding for the MNIST layer sequencer.
package mnist_pkg;
  localparam int VEC_LEN_D     = 784;
  localparam int NUM_NEURONS_D = 10;
  localparam int ACC_W_D       = 32;
  localparam int MAC_W         = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits for a depth of 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_addr_gen.sv
// Element/neuron counters for neuron_seq; weight address tracks n*VEC_LEN
// incrementally so no multiplier is needed.
module seq_addr_gen import mnist_pkg::*; #(
  parameter int VEC_LEN     = VEC_LEN_D,
  parameter int NUM_NEURONS = NUM_NEURONS_D,
  localparam int EW = cw(VEC_LEN),
  localparam int NW = cw(NUM_NEURONS),
  localparam int WW = cw(VEC_LEN*NUM_NEURONS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_step,
  input  logic          i_next,
  output logic [EW-1:0] o_e,
  output logic [NW-1:0] o_n,
  output logic [WW-1:0] o_waddr,
  output logic          o_last_e,
  output logic          o_last_n
);
  localparam logic [EW-1:0] E_LAST = EW'(VEC_LEN-1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS-1);
  localparam logic [WW-1:0] STRIDE = WW'(VEC_LEN);

  logic [EW-1:0] r_e;
  logic [NW-1:0] r_n;
  logic [WW-1:0] r_base;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_e    <= '0;
      r_n    <= '0;
      r_base <= '0;
    end else if (i_clr) begin
      r_e    <= '0;
      r_n    <= '0;
      r_base <= '0;
    end else begin
      // Element counter wraps so the next neuron starts at e=0.
      if (i_step) r_e <= o_last_e ? '0 : r_e + 1'b1;
      if (i_next) begin
        r_n    <= r_n + 1'b1;
        r_base <= r_base + STRIDE;
      end
    end
  end

  assign o_e      = r_e;
  assign o_n      = r_n;
  assign o_waddr  = r_base + WW'(r_e);
  assign o_last_e = (r_e == E_LAST);
  assign o_last_n = (r_n == N_LAST);
endmodule

// File: rtl/neuron_seq.sv
// Layer sequencer: streams feature/weight reads into an external MAC and
// accumulates one dot product per neuron. Define NEURON_SEQ_RELU_EN to clamp
// negative sums to zero on out_data.
module neuron_seq import mnist_pkg::*; #(
  parameter int VEC_LEN     = VEC_LEN_D,
  parameter int NUM_NEURONS = NUM_NEURONS_D,
  parameter int ACC_W       = ACC_W_D,
  localparam int EW = cw(VEC_LEN),
  localparam int NW = cw(NUM_NEURONS),
  localparam int WW = cw(VEC_LEN*NUM_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    feat_rd_en,
  output logic [EW-1:0]           feat_addr,
  output logic                    wt_rd_en,
  output logic [WW-1:0]           wt_addr,
  output logic                    mac_en,
  output logic                    mac_last_in,
  input  logic signed [MAC_W-1:0] mac_result,
  input  logic                    mac_last_out,
  input  logic                    mac_done,
  output logic signed [ACC_W-1:0] out_data,
  output logic [NW-1:0]           out_idx,
  output logic                    out_valid,
  input  logic                    out_ready
);
  state_t                  r_state, w_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_ext;
  logic                    r_mac_en, r_mac_last, r_layer_done;
  logic                    w_last_e, w_last_n, w_clr, w_step, w_next, w_hs;

  assign w_hs   = (r_state == S_OUT) && out_ready;
  assign w_clr  = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_RUN);
  assign w_next = w_hs && !w_last_n;
  assign w_ext  = {{(ACC_W-MAC_W){mac_result[MAC_W-1]}}, mac_result};

  seq_addr_gen #(.VEC_LEN(VEC_LEN), .NUM_NEURONS(NUM_NEURONS)) u_addr (
    .clk(clk), .rstn(rstn), .i_clr(w_clr), .i_step(w_step), .i_next(w_next),
    .o_e(feat_addr), .o_n(out_idx), .o_waddr(wt_addr),
    .o_last_e(w_last_e), .o_last_n(w_last_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_RUN;
      S_RUN:   if (w_last_e) w_nxt = S_DRAIN;
      S_DRAIN: if (mac_done && mac_last_out) w_nxt = S_OUT;
      S_OUT:   if (out_ready) w_nxt = w_last_n ? S_IDLE : S_RUN;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    feat_rd_en = (r_state == S_RUN);
    wt_rd_en   = (r_state == S_RUN);
    out_valid  = (r_state == S_OUT);
  end

  // Products are only summed while a neuron is in flight, so stale MAC
  // results arriving in IDLE after a reset leave the accumulator alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mac_en     <= 1'b0;
      r_mac_last   <= 1'b0;
      r_layer_done <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_mac_en     <= feat_rd_en;
      r_mac_last   <= feat_rd_en && w_last_e;
      r_layer_done <= w_hs && w_last_n;
      if (w_clr || w_next)
        r_acc <= '0;
      else if (mac_done && (r_state == S_RUN || r_state == S_DRAIN))
        r_acc <= r_acc + w_ext;
    end
  end

  assign mac_en      = r_mac_en;
  assign mac_last_in = r_mac_last;
  assign layer_done  = r_layer_done;

`ifdef NEURON_SEQ_RELU_EN
  assign out_data = r_acc[ACC_W-1] ? '0 : r_acc;
`else
  assign out_data = r_acc;
`endif
endmodule

// File: doc/neuron_seq.md
NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 SHALL have parameter VEC_LEN, default 784, meaning elements per dot product.
REQ-002 SHALL have parameter NUM_NEURONS, default 10, meaning neurons per layer.
REQ-003 SHALL have parameter ACC_W, default 32, meaning accumulator/output width.
REQ-004 Ports, in order:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin layer; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- layer_done  out  1  one-cycle pulse after the final neuron handshake.
- feat_rd_en  out  1  feature memory read strobe.
- feat_addr  out  clog2(VEC_LEN)  feature memory address.
- wt_rd_en  out  1  weight memory read strobe.
- wt_addr  out  clog2(VEC_LEN*NUM_NEURONS)  weight memory address.
- mac_en  out  1  MAC enable.
- mac_last_in  out  1  MAC last-element flag.
- mac_result  in  16 signed  MAC product.
- mac_last_out  in  1  MAC last flag, delayed.
- mac_done  in  1  MAC product valid.
- out_data  out  ACC_W signed  neuron sum.
- out_idx  out  clog2(NUM_NEURONS)  neuron index.
- out_valid  out  1  output valid.
- out_ready  in  1  output accept.
REQ-005 Memory read data (1-cycle synchronous read latency) SHALL be wired directly to MAC input_feature/weight at top level; neuron_seq carries no data bytes.

Function
REQ-006 FSM states: IDLE, RUN, DRAIN, OUT.
REQ-007 IDLE->RUN on start; counters and accumulator clear on this transition.
REQ-008 RUN: one read per cycle with feat_rd_en=wt_rd_en=1, feat_addr=e, wt_addr=n*VEC_LEN+e, for e=0..VEC_LEN-1; RUN->DRAIN after e=VEC_LEN-1.
REQ-009 mac_en SHALL be rd_en delayed 1 cycle; mac_last_in SHALL be (e==VEC_LEN-1) delayed 1 cycle.
REQ-010 Each cycle with mac_done=1: acc <= acc + sign-extended mac_result.
REQ-011 DRAIN->OUT on the cycle mac_done&mac_last_out=1; that final product is included in out_data.
REQ-012 out_valid SHALL rise VEC_LEN+4 cycles after the cycle start is sampled (MAC latency 2).
REQ-013 OUT: out_valid=1; out_data and out_idx SHALL stay stable until out_ready=1.
REQ-014 On handshake with n<NUM_NEURONS-1: n++, acc clears, OUT->RUN.
REQ-015 On handshake with n=NUM_NEURONS-1: OUT->IDLE, layer_done pulses for 1 cycle.
REQ-016 start SHALL be ignored when busy=1.
REQ-017 out_ready SHALL be ignored outside OUT.
REQ-018 mac_done while in IDLE SHALL NOT modify acc.
REQ-019 ACC_W SHALL be >= 16+clog2(VEC_LEN); the accumulator wraps modulo 2^ACC_W with no saturation.

Reset
REQ-020 rstn low SHALL asynchronously force IDLE and zero every output, counter and acc, including mid-RUN and mid-OUT.
REQ-021 After reset release, MAC results still in flight SHALL be discarded (REQ-018).

Configuration
REQ-022 With NEURON_SEQ_RELU_EN defined, out_data SHALL be 0 when acc<0, otherwise acc.
REQ-023 Without NEURON_SEQ_RELU_EN, out_data SHALL equal acc exactly.

Structure
REQ-024 Shared package mnist_pkg SHALL hold VEC_LEN, NUM_NEURONS, ACC_W defaults and the FSM state encoding.
REQ-025 Address/element counter SHALL be sub-module seq_addr_gen (element and neuron counters, last flag).
REQ-026 The MAC is instantiated beside neuron_seq at top level, not inside it.

Verification (VEC_LEN=4, NUM_NEURONS=2, MAC model instantiated)
REQ-027 Features {1,2,3,4}, weights n0 {1,1,1,1}, n1 {-1,-1,-1,-1}, out_ready=1 -> outputs (idx0, 10) then (idx1, -10), or 0 with RELU_EN; layer_done once.
REQ-028 start at cycle 0 -> out_valid first high at cycle 8; wt_addr sequence 0,1,2,3 then 4,5,6,7.
REQ-029 out_ready=0 for 5 cycles in OUT -> out_data and out_idx held, no reads issued; resumes after acceptance.
REQ-030 start pulsed during RUN -> ignored; exactly 2 outputs produced.
REQ-031 rstn low mid-RUN (e=2) -> all outputs 0 immediately; new start yields correct sum 10 for n0.
REQ-032 Features 255, weights -128, VEC_LEN=784 -> out_data = -25,589,760, no wrap.
